uart_tx_fifo: RTL

Buffered 8N1 UART transmitter that consumes the byte stream produced by the word-to-byte serialiser in the boot path and drives the board TX pin. Bytes arrive as single-cycle `dat_en` strobes. They are queued in a small FIFO and shifted out LSB-first, back-to-back, at a fixed bit period. This absorbs bursts from the RAM dump so the upstream sequencer never has to wait on line timing.

---
 rtl/uart_tx_fifo_if.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte-write and status bundle for the buffered UART transmitter
//
// Signals:
//   dat_en    write strobe, one byte per high cycle
//   dat       byte to queue, sampled while dat_en=1
//   tx        serial line, idle high
//   full      FIFO holds 2^FIFO_AW entries
//   empty     FIFO holds 0 entries
//   level     FIFO occupancy, FIFO_AW+1 bits
//   busy      a frame is on the line
//   overflow  sticky: a write was dropped since reset
//
// master: the byte producer (drives dat_en/dat, observes status and tx)
// slave : the transmitter

interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 4
);

  logic               dat_en;
  logic [7:0]         dat;
  logic               tx;
  logic               full;
  logic               empty;
  logic [FIFO_AW:0]   level;
  logic               busy;
  logic               overflow;

  modport master (
    output dat_en,
    output dat,
    input  tx,
    input  full,
    input  empty,
    input  level,
    input  busy,
    input  overflow
  );

  modport slave (
    input  dat_en,
    input  dat,
    output tx,
    output full,
    output empty,
    output level,
    output busy,
    output overflow
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   uart_tx_fifo_if.slave: dat_en/dat in; tx, full, empty, level,
//         busy, overflow out
//
// Bytes are queued in a 2^FIFO_AW entry circular buffer and shifted out
// LSB-first as start + 8 data + stop, CLKS_PER_BIT clocks per bit. A byte
// waiting at the end of a stop bit starts its frame on the very next cycle.

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int LVL_W  = FIFO_AW + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               full;
  logic               empty;
  logic               overflow;
  logic               wr_accept;
  logic               wr_drop;
  logic               pop;

  // Transmit FSM
  logic [1:0]         state;
  logic [1:0]         state_n;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BAUD_W-1:0]  baud_cnt_n;
  logic [2:0]         bit_idx;
  logic [2:0]         bit_idx_n;
  logic [7:0]         shift;
  logic [7:0]         shift_n;
  logic               tx;
  logic               tx_n;
  logic               baud_last;

  // full/empty decode straight from the level flop, so a write in this
  // cycle is judged against the occupancy at the start of the cycle.
  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign wr_accept = bus.dat_en && !full;
  // A pop in the same cycle does not rescue a write that arrives while full.
  assign wr_drop   = bus.dat_en && full;
  assign baud_last = (baud_cnt == BAUD_LAST);

  // Storage is not reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Every state change happens on the last baud cycle, where the counter
  // wraps to 0, so the natural wrap doubles as the clear-on-entry.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_last ? '0 : baud_cnt + 1'b1;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    pop        = 1'b0;

    case (state)
      S_IDLE: begin
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = S_START;
        end
      end

      S_START: begin
        if (baud_last) begin
          bit_idx_n = '0;
          state_n   = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (baud_last) begin
          bit_idx_n = '0;
          if (!empty) begin
            // Chain straight into the next start bit: no idle cycle.
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Line level comes from the state being entered, so tx changes on the
    // same edge as the state register.
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  assign bus.tx       = tx;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.busy     = (state != S_IDLE);
  assign bus.overflow = overflow;

endmodule
